sram16384x112_arbiter: RTL

- Shares the single-port 16384x112 frame SRAM between two requesters in the JPEG decoder.
  - Write client: the entropy/dequant stage storing 112-bit coefficient words.
  - Read client: the IDCT/output stage fetching them.
- Sequences the SRAM NCE/NWRT/RA/CA/DIN pins with registered outputs.
- Tracks in-flight reads and returns read data with a valid strobe.
- Write has priority; a starvation counter guarantees reads get bandwidth.

---
 rtl/sram16384x112_arbiter.sv | 93 +++++++++
 1 files changed

// File: rtl/sram16384x112_arbiter.sv
// Arbitrates the single-port 16384x112 frame SRAM between a write client and a read client.
// Writes win ties until MAXWRBURST consecutive writes have starved a pending read.
module sram16384x112_arbiter #(
  parameter int ADDRESSSIZE = 14,
  parameter int WORDSIZE    = 112,
  parameter int MAXWRBURST  = 4
) (
  input  logic                   iClk,
  input  logic                   iReset,
  input  logic                   iWrReq,
  input  logic [ADDRESSSIZE-1:0] iWrAddr,
  input  logic [WORDSIZE-1:0]    iWrData,
  output logic                   oWrAck,
  input  logic                   iRdReq,
  input  logic [ADDRESSSIZE-1:0] iRdAddr,
  output logic                   oRdAck,
  output logic                   oRdValid,
  output logic [WORDSIZE-1:0]    oRdData,
  output logic                   oNCE,
  output logic                   oNWRT,
  output logic [ADDRESSSIZE-2:0] oRA,
  output logic                   oCA,
  output logic [WORDSIZE-1:0]    oDIN,
  input  logic [WORDSIZE-1:0]    iDO
);

  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_WR,
    GNT_RD
  } grant_t;

  localparam logic [3:0] MAX_CNT = 4'(MAXWRBURST);

  grant_t     grant;
  logic [3:0] wrcnt;
  logic [1:0] rd_pipe;

  always_comb begin
    grant = GNT_IDLE;
    if (iReset) begin
      if (iWrReq && (!iRdReq || (wrcnt < MAX_CNT)))
        grant = GNT_WR;
      else if (iRdReq)
        grant = GNT_RD;
    end
  end

  assign oWrAck   = (grant == GNT_WR);
  assign oRdAck   = (grant == GNT_RD);
  assign oRdValid = rd_pipe[1];
  assign oRdData  = iDO;

  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      oNCE    <= 1'b1;
      oNWRT   <= 1'b1;
      oRA     <= '0;
      oCA     <= 1'b0;
      oDIN    <= '0;
      rd_pipe <= '0;
      wrcnt   <= '0;
    end else begin
      case (grant)
        GNT_WR: begin
          oNCE       <= 1'b0;
          oNWRT      <= 1'b0;
          {oRA, oCA} <= iWrAddr;
          oDIN       <= iWrData;
        end
        GNT_RD: begin
          oNCE       <= 1'b0;
          oNWRT      <= 1'b1;
          {oRA, oCA} <= iRdAddr;
        end
        default: begin
          oNCE  <= 1'b1;
          oNWRT <= 1'b1;
        end
      endcase

      // SRAM registers Q one edge after the command, so data lands two cycles after the grant
      rd_pipe <= {rd_pipe[0], (grant == GNT_RD)};

      // The counter only measures a streak of writes that actually kept a read waiting
      if (!iRdReq || (grant == GNT_RD))
        wrcnt <= '0;
      else if ((grant == GNT_WR) && (wrcnt < MAX_CNT))
        wrcnt <= wrcnt + 4'd1;
    end
  end

endmodule
